// File: rtl/reg_status_file_pkg.sv
// Shared core widths: register file geometry and ROB tag width, also used by the ROB.
package reg_status_file_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_IDX_W = $clog2(DEF_NREG);

    typedef logic [DEF_IDX_W-1:0] reg_idx_t;
    typedef logic [DEF_TAG_W-1:0] rob_tag_t;
    typedef logic [DEF_XLEN-1:0]  xlen_t;
endpackage

// File: rtl/reg_read_port.sv
// One decode source operand: x0 forcing and same-cycle commit bypass over the stored entry.
// Purely combinational, zero latency; never stalls.
module reg_read_port
    import reg_status_file_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_TAG_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             ent_busy_i,
    input  logic [XLEN-1:0]  ent_val_i,
    input  logic [TAG_W-1:0] ent_tag_i,
    input  logic             commit_en_i,
    input  logic [IDX_W-1:0] commit_idx_i,
    input  logic [XLEN-1:0]  commit_val_i,
    input  logic [TAG_W-1:0] commit_tag_i,
    output logic             busy_o,
    output logic [XLEN-1:0]  val_o,
    output logic [TAG_W-1:0] tag_o
);
    always_comb begin
        busy_o = ent_busy_i;
        val_o  = ent_val_i;
        tag_o  = ent_tag_i;
        if (idx_i == '0) begin
            busy_o = 1'b0;
            val_o  = '0;
            tag_o  = '0;
        end else if (commit_en_i && commit_idx_i == idx_i && ent_busy_i &&
                     ent_tag_i == commit_tag_i) begin
            // The producer retires this cycle: hand its value straight to decode.
            busy_o = 1'b0;
            val_o  = commit_val_i;
        end
    end
endmodule

// File: rtl/reg_status_file.sv
// Architectural registers plus per-register rename (busy/tag) state between decode and the ROB.
// Reads are combinational; updates land on the clock edge when rdy_in is high.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic [4:0]       rs1_idx,
    input  logic [4:0]       rs2_idx,
    output logic             rs1_busy,
    output logic [XLEN-1:0]  rs1_val,
    output logic [TAG_W-1:0] rs1_tag,
    output logic             rs2_busy,
    output logic [XLEN-1:0]  rs2_val,
    output logic [TAG_W-1:0] rs2_tag,
    input  logic             rename_en,
    input  logic [4:0]       rename_idx,
    input  logic [TAG_W-1:0] rename_tag,
    input  logic             commit_en,
    input  logic [4:0]       commit_idx,
    input  logic [XLEN-1:0]  commit_val,
    input  logic [TAG_W-1:0] commit_tag
);
    logic [XLEN-1:0]  val_q  [NREG];
    logic [XLEN-1:0]  val_d  [NREG];
    logic             busy_q [NREG];
    logic             busy_d [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];

    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        // Entry 0 is never updated so x0 stays zero/idle.
        for (int i = 1; i < NREG; i++) begin
            if (commit_en && commit_idx == 5'(i)) begin
                val_d[i] = commit_val;
            end
            if (flush_in) begin
                busy_d[i] = 1'b0;
            end else if (rename_en && rename_idx == 5'(i)) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = rename_tag;
            end else if (commit_en && commit_idx == 5'(i) && tag_q[i] == commit_tag) begin
                // A mismatching tag means a younger producer still owns the register.
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    reg_read_port #(.XLEN(XLEN), .TAG_W(TAG_W), .IDX_W(5)) u_rs1 (
        .idx_i        (rs1_idx),
        .ent_busy_i   (busy_q[rs1_idx]),
        .ent_val_i    (val_q[rs1_idx]),
        .ent_tag_i    (tag_q[rs1_idx]),
        .commit_en_i  (commit_en),
        .commit_idx_i (commit_idx),
        .commit_val_i (commit_val),
        .commit_tag_i (commit_tag),
        .busy_o       (rs1_busy),
        .val_o        (rs1_val),
        .tag_o        (rs1_tag)
    );

    reg_read_port #(.XLEN(XLEN), .TAG_W(TAG_W), .IDX_W(5)) u_rs2 (
        .idx_i        (rs2_idx),
        .ent_busy_i   (busy_q[rs2_idx]),
        .ent_val_i    (val_q[rs2_idx]),
        .ent_tag_i    (tag_q[rs2_idx]),
        .commit_en_i  (commit_en),
        .commit_idx_i (commit_idx),
        .commit_val_i (commit_val),
        .commit_tag_i (commit_tag),
        .busy_o       (rs2_busy),
        .val_o        (rs2_val),
        .tag_o        (rs2_tag)
    );
endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: a cycle-by-cycle vector table plus reset/stall sequences.
module tb_reg_status_file;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic [4:0]  rs1_idx, rs2_idx;
    logic        rs1_busy, rs2_busy;
    logic [31:0] rs1_val, rs2_val;
    logic [3:0]  rs1_tag, rs2_tag;
    logic        rename_en, commit_en;
    logic [4:0]  rename_idx, commit_idx;
    logic [3:0]  rename_tag, commit_tag;
    logic [31:0] commit_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    reg_status_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
        .rename_en(rename_en), .rename_idx(rename_idx), .rename_tag(rename_tag),
        .commit_en(commit_en), .commit_idx(commit_idx), .commit_val(commit_val),
        .commit_tag(commit_tag)
    );

    // One row = inputs driven for one cycle plus the read results expected in that cycle
    // (before its clock edge). val is checked when not busy, tag when busy or index 0.
    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        ren;
        logic [4:0]  ridx;
        logic [3:0]  rtag;
        logic        cen;
        logic [4:0]  cidx;
        logic [31:0] cval;
        logic [3:0]  ctag;
        logic        flush;
        logic        e1b;
        logic [31:0] e1v;
        logic [3:0]  e1t;
        logic        e2b;
        logic [31:0] e2v;
        logic [3:0]  e2t;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic ren, input logic [4:0] ridx, input logic [3:0] rtag,
                                input logic cen, input logic [4:0] cidx, input logic [31:0] cval,
                                input logic [3:0] ctag, input logic flush,
                                input logic e1b, input logic [31:0] e1v, input logic [3:0] e1t,
                                input logic e2b, input logic [31:0] e2v, input logic [3:0] e2t);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.ren = ren; v.ridx = ridx; v.rtag = rtag;
        v.cen = cen; v.cidx = cidx; v.cval = cval; v.ctag = ctag; v.flush = flush;
        v.e1b = e1b; v.e1v = e1v; v.e1t = e1t; v.e2b = e2b; v.e2v = e2v; v.e2t = e2t;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush_in = 0; rename_en = 0; rename_idx = 0; rename_tag = 0;
        commit_en = 0; commit_idx = 0; commit_val = 0; commit_tag = 0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] idx1, input logic [4:0] idx2,
                            input logic eb1, input logic [31:0] ev1,
                            input logic eb2, input logic [31:0] ev2);
        rs1_idx = idx1; rs2_idx = idx2;
        #1;
        check({name, ".rs1_busy"}, 32'(rs1_busy), 32'(eb1));
        if (!eb1) check({name, ".rs1_val"}, rs1_val, ev1);
        check({name, ".rs2_busy"}, 32'(rs2_busy), 32'(eb2));
        if (!eb2) check({name, ".rs2_val"}, rs2_val, ev2);
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; rs1_idx = 0; rs2_idx = 0;
        idle_inputs();

        //   rs1 rs2 ren ridx rtag cen cidx cval          ctag fl  e1b e1v           e1t e2b e2v           e2t
        add(5,  0,  0, 0,  0,  0, 0,  32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h0,        0);
        add(3,  0,  0, 0,  0,  1, 3,  32'hDEADBEEF, 0, 0,  0, 32'h0,        0, 0, 32'h0,        0);
        add(3,  7,  1, 7,  2,  0, 0,  32'h0,        0, 0,  0, 32'hDEADBEEF, 0, 0, 32'h0,        0);
        add(7,  3,  0, 0,  0,  0, 0,  32'h0,        0, 0,  1, 32'h0,        2, 0, 32'hDEADBEEF, 0);
        add(7,  7,  0, 0,  0,  1, 7,  32'h11,       2, 0,  0, 32'h11,       0, 0, 32'h11,       0);
        add(7,  0,  1, 7,  2,  0, 0,  32'h0,        0, 0,  0, 32'h11,       0, 0, 32'h0,        0);
        add(7,  0,  1, 7,  5,  0, 0,  32'h0,        0, 0,  1, 32'h0,        2, 0, 32'h0,        0);
        add(7,  0,  0, 0,  0,  1, 7,  32'h22,       2, 0,  1, 32'h0,        5, 0, 32'h0,        0);
        add(7,  7,  0, 0,  0,  1, 7,  32'h33,       5, 0,  0, 32'h33,       0, 0, 32'h33,       0);
        add(7,  0,  1, 9,  1,  0, 0,  32'h0,        0, 0,  0, 32'h33,       0, 0, 32'h0,        0);
        add(9,  0,  1, 9,  4,  1, 9,  32'h99,       1, 0,  0, 32'h99,       0, 0, 32'h0,        0);
        add(9,  9,  1, 1,  0,  0, 0,  32'h0,        0, 0,  1, 32'h0,        4, 1, 32'h0,        4);
        add(1,  0,  1, 2,  1,  0, 0,  32'h0,        0, 0,  1, 32'h0,        0, 0, 32'h0,        0);
        add(2,  0,  1, 31, 15, 0, 0,  32'h0,        0, 0,  1, 32'h0,        1, 0, 32'h0,        0);
        add(31, 4,  1, 6,  3,  1, 4,  32'h44,       0, 1,  1, 32'h0,       15, 0, 32'h0,        0);
        add(1,  2,  0, 0,  0,  0, 0,  32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h0,        0);
        add(31, 4,  0, 0,  0,  0, 0,  32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h44,       0);
        add(6,  9,  1, 0,  3,  1, 0,  32'hFF,       0, 0,  0, 32'h0,        0, 0, 32'h99,       0);
        add(0,  0,  1, 0,  3,  1, 0,  32'hFF,       0, 0,  0, 32'h0,        0, 0, 32'h0,        0);
        add(0,  0,  0, 0,  0,  0, 0,  32'h0,        0, 0,  0, 32'h0,        0, 0, 32'h0,        0);

        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 0;

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            rs1_idx = vecs[i].rs1; rs2_idx = vecs[i].rs2;
            rename_en = vecs[i].ren; rename_idx = vecs[i].ridx; rename_tag = vecs[i].rtag;
            commit_en = vecs[i].cen; commit_idx = vecs[i].cidx;
            commit_val = vecs[i].cval; commit_tag = vecs[i].ctag;
            flush_in = vecs[i].flush;
            #1;
            check({nm, ".rs1_busy"}, 32'(rs1_busy), 32'(vecs[i].e1b));
            if (!vecs[i].e1b) check({nm, ".rs1_val"}, rs1_val, vecs[i].e1v);
            if (vecs[i].e1b || vecs[i].rs1 == 5'd0) check({nm, ".rs1_tag"}, 32'(rs1_tag), 32'(vecs[i].e1t));
            check({nm, ".rs2_busy"}, 32'(rs2_busy), 32'(vecs[i].e2b));
            if (!vecs[i].e2b) check({nm, ".rs2_val"}, rs2_val, vecs[i].e2v);
            if (vecs[i].e2b || vecs[i].rs2 == 5'd0) check({nm, ".rs2_tag"}, 32'(rs2_tag), 32'(vecs[i].e2t));
            @(negedge clk_in);
        end
        idle_inputs();

        // Stall: with rdy_in low, rename/commit/flush must all be ignored.
        rdy_in = 0;
        rename_en = 1; rename_idx = 10; rename_tag = 6;
        commit_en = 1; commit_idx = 4; commit_val = 32'h55; commit_tag = 0;
        @(negedge clk_in);
        idle_inputs();
        read_chk("stall", 10, 4, 0, 32'h0, 0, 32'h44);
        rdy_in = 1;

        // Rename x10 so it is pending, then reset alongside a commit and rename.
        rename_en = 1; rename_idx = 10; rename_tag = 6;
        @(negedge clk_in);
        idle_inputs();
        rs1_idx = 10;
        #1;
        check("pre_rst.rs1_busy", 32'(rs1_busy), 32'd1);
        check("pre_rst.rs1_tag", 32'(rs1_tag), 32'd6);
        rst_in = 1;
        commit_en = 1; commit_idx = 11; commit_val = 32'hAB; commit_tag = 0;
        rename_en = 1; rename_idx = 12; rename_tag = 7;
        @(negedge clk_in);
        rst_in = 0;
        idle_inputs();
        read_chk("rst_a", 10, 11, 0, 32'h0, 0, 32'h0);
        read_chk("rst_b", 12, 4, 0, 32'h0, 0, 32'h0);
        read_chk("rst_c", 3, 9, 0, 32'h0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
